// File: rtl/morse_pkg.sv
// Shared glyph constants for the Morse-to-7-segment display path.
// Glyphs are stored active-high {g,f,e,d,c,b,a}; seg_inv gives the cathode form.
package morse_pkg;

   localparam int MAX_SYMBOLS = 5;

   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;
   localparam logic [6:0] SEG_G = 7'h3D;
   localparam logic [6:0] SEG_H = 7'h76;
   localparam logic [6:0] SEG_I = 7'h30;
   localparam logic [6:0] SEG_J = 7'h1E;
   localparam logic [6:0] SEG_K = 7'h75;
   localparam logic [6:0] SEG_L = 7'h38;
   localparam logic [6:0] SEG_M = 7'h55;
   localparam logic [6:0] SEG_N = 7'h54;
   localparam logic [6:0] SEG_O = 7'h5C;
   localparam logic [6:0] SEG_P = 7'h73;
   localparam logic [6:0] SEG_Q = 7'h67;
   localparam logic [6:0] SEG_R = 7'h50;
   localparam logic [6:0] SEG_S = 7'h6D;
   localparam logic [6:0] SEG_T = 7'h78;
   localparam logic [6:0] SEG_U = 7'h3E;
   localparam logic [6:0] SEG_V = 7'h1C;
   localparam logic [6:0] SEG_W = 7'h2A;
   localparam logic [6:0] SEG_X = 7'h64;
   localparam logic [6:0] SEG_Y = 7'h6E;
   localparam logic [6:0] SEG_Z = 7'h5B;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   // Active-low forms driven straight onto the cathodes.
   localparam logic [6:0] BLANK_SEG = 7'h7F;
   localparam logic [6:0] ERR_SEG   = 7'h3F;

   function automatic logic [6:0] seg_inv(input logic [6:0] g);
      return ~g;
   endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational (length, code) -> active-low glyph table.
// Only the low len_i bits of code_i take part in the lookup.
module morse_lut
   import morse_pkg::*;
#(
   parameter logic [6:0] BLANK = BLANK_SEG,
   parameter logic [6:0] ERR   = ERR_SEG
) (
   input  logic [2:0] len_i,
   input  logic [4:0] code_i,
   output logic [6:0] seg_o
);

   logic [6:0] hi;
   logic       hit;

   always_comb begin
      hi  = '0;
      hit = 1'b1;
      unique case (len_i)
         3'd1: hi = code_i[0] ? SEG_T : SEG_E;
         3'd2: begin
            unique case (code_i[1:0])
               2'b00: hi = SEG_I;
               2'b01: hi = SEG_A;
               2'b10: hi = SEG_N;
               2'b11: hi = SEG_M;
            endcase
         end
         3'd3: begin
            unique case (code_i[2:0])
               3'b000: hi = SEG_S;
               3'b001: hi = SEG_U;
               3'b010: hi = SEG_R;
               3'b011: hi = SEG_W;
               3'b100: hi = SEG_D;
               3'b101: hi = SEG_K;
               3'b110: hi = SEG_G;
               3'b111: hi = SEG_O;
            endcase
         end
         3'd4: begin
            case (code_i[3:0])
               4'b0000: hi = SEG_H;
               4'b0001: hi = SEG_V;
               4'b0010: hi = SEG_F;
               4'b0100: hi = SEG_L;
               4'b0110: hi = SEG_P;
               4'b0111: hi = SEG_J;
               4'b1000: hi = SEG_B;
               4'b1001: hi = SEG_X;
               4'b1010: hi = SEG_C;
               4'b1011: hi = SEG_Y;
               4'b1100: hi = SEG_Z;
               4'b1101: hi = SEG_Q;
               default: hit = 1'b0;
            endcase
         end
         3'd5: begin
            case (code_i)
               5'b01111: hi = SEG_1;
               5'b00111: hi = SEG_2;
               5'b00011: hi = SEG_3;
               5'b00001: hi = SEG_4;
               5'b00000: hi = SEG_5;
               5'b10000: hi = SEG_6;
               5'b11000: hi = SEG_7;
               5'b11100: hi = SEG_8;
               5'b11110: hi = SEG_9;
               5'b11111: hi = SEG_0;
               default:  hit = 1'b0;
            endcase
         end
         default: hit = 1'b0;
      endcase
   end

   always_comb begin
      if (len_i == 3'd0) seg_o = BLANK;
      else if (hit)      seg_o = seg_inv(hi);
      else               seg_o = ERR;
   end

endmodule

// File: rtl/morse_decoder_7seg.sv
// One Morse character in, one registered active-low 7-segment glyph out.
// Output register resets asynchronously to the blank pattern.
module morse_decoder_7seg
   import morse_pkg::*;
#(
   parameter logic [6:0] BLANK_SEG = morse_pkg::BLANK_SEG,
   parameter logic [6:0] ERR_SEG   = morse_pkg::ERR_SEG
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] possible_chars,
   input  logic [2:0] possible_inputs,
   output logic [6:0] display
);

   logic [6:0] display_d;
   logic [6:0] display_q;

   morse_lut #(
      .BLANK (BLANK_SEG),
      .ERR   (ERR_SEG)
   ) u_lut (
      .len_i  (possible_inputs),
      .code_i (possible_chars),
      .seg_o  (display_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) display_q <= BLANK_SEG;
      else        display_q <= display_d;
   end

   assign display = display_q;

endmodule

// File: tb/tb_morse_decoder_7seg.sv
// Directed checks of the Morse 7-segment decoder.
// Expected glyphs are hand-computed active-low constants.
module tb_morse_decoder_7seg;

   logic       clk;
   logic       rst_n;
   logic [4:0] possible_chars;
   logic [2:0] possible_inputs;
   logic [6:0] display;

   int errors = 0;
   int checks = 0;

   morse_decoder_7seg dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .possible_chars  (possible_chars),
      .possible_inputs (possible_inputs),
      .display         (display)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {len, code, expected display}
   localparam logic [14:0] TBL [36] = '{
      {3'd1, 5'b00000, 7'h06}, {3'd1, 5'b00001, 7'h07},
      {3'd2, 5'b00000, 7'h4F}, {3'd2, 5'b00001, 7'h08},
      {3'd2, 5'b00010, 7'h2B}, {3'd2, 5'b00011, 7'h2A},
      {3'd3, 5'b00000, 7'h12}, {3'd3, 5'b00001, 7'h41},
      {3'd3, 5'b00010, 7'h2F}, {3'd3, 5'b00011, 7'h55},
      {3'd3, 5'b00100, 7'h21}, {3'd3, 5'b00101, 7'h0A},
      {3'd3, 5'b00110, 7'h42}, {3'd3, 5'b00111, 7'h23},
      {3'd4, 5'b00000, 7'h09}, {3'd4, 5'b00001, 7'h63},
      {3'd4, 5'b00010, 7'h0E}, {3'd4, 5'b00100, 7'h47},
      {3'd4, 5'b00110, 7'h0C}, {3'd4, 5'b00111, 7'h61},
      {3'd4, 5'b01000, 7'h03}, {3'd4, 5'b01001, 7'h1B},
      {3'd4, 5'b01010, 7'h46}, {3'd4, 5'b01011, 7'h11},
      {3'd4, 5'b01100, 7'h24}, {3'd4, 5'b01101, 7'h18},
      {3'd5, 5'b01111, 7'h79}, {3'd5, 5'b00111, 7'h24},
      {3'd5, 5'b00011, 7'h30}, {3'd5, 5'b00001, 7'h19},
      {3'd5, 5'b00000, 7'h12}, {3'd5, 5'b10000, 7'h02},
      {3'd5, 5'b11000, 7'h78}, {3'd5, 5'b11100, 7'h00},
      {3'd5, 5'b11110, 7'h10}, {3'd5, 5'b11111, 7'h40}
   };

   task automatic drive(input logic [2:0] len, input logic [4:0] ch);
      @(negedge clk);
      possible_inputs = len;
      possible_chars  = ch;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      possible_inputs = 3'd0;
      possible_chars  = 5'd0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (display !== 7'h7F) begin
         errors++;
         $display("FAIL reset_async: got %h want 7f", display);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (display !== 7'h7F) begin
         errors++;
         $display("FAIL reset_release: got %h want 7f", display);
      end
   endtask

   task automatic test_letters();
      logic [2:0] l [3] = '{3'd1, 3'd2, 3'd4};
      logic [4:0] c [3] = '{5'b00000, 5'b00001, 5'b01010};
      logic [6:0] e [3] = '{7'h06, 7'h08, 7'h46};
      logic [6:0] prev;
      for (int i = 0; i < 3; i++) begin
         prev = display;
         drive(l[i], c[i]);
         #1;
         checks++;
         if (display !== prev) begin
            errors++;
            $display("FAIL letter_early[%0d]: got %h want %h",
                     i, display, prev);
         end
         @(posedge clk); #1;
         checks++;
         if (display !== e[i]) begin
            errors++;
            $display("FAIL letter[%0d]: got %h want %h", i, display, e[i]);
         end
      end
   endtask

   task automatic test_digits();
      logic [4:0] c [3] = '{5'b11111, 5'b01111, 5'b11110};
      logic [6:0] e [3] = '{7'h40, 7'h79, 7'h10};
      for (int i = 0; i < 3; i++) begin
         drive(3'd5, c[i]);
         @(posedge clk); #1;
         checks++;
         if (display !== e[i]) begin
            errors++;
            $display("FAIL digit[%0d]: got %h want %h", i, display, e[i]);
         end
      end
   endtask

   task automatic test_dontcare();
      logic [4:0] c [2] = '{5'b11110, 5'b00000};
      for (int i = 0; i < 2; i++) begin
         drive(3'd0, 5'd0);
         @(posedge clk);
         drive(3'd1, c[i]);
         @(posedge clk); #1;
         checks++;
         if (display !== 7'h06) begin
            errors++;
            $display("FAIL dontcare[%0d]: got %h want 06", i, display);
         end
      end
      drive(3'd2, 5'b11101);
      @(posedge clk); #1;
      checks++;
      if (display !== 7'h08) begin
         errors++;
         $display("FAIL dontcare_len2: got %h want 08", display);
      end
   endtask

   task automatic test_invalid();
      logic [2:0] l [7] = '{3'd4, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      logic [4:0] c [7] = '{5'b01111, 5'b00011, 5'b00101,
                            5'b01010, 5'b00000, 5'b11111, 5'b11111};
      logic [6:0] e [7] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F,
                            7'h3F, 7'h3F, 7'h7F};
      for (int i = 0; i < 7; i++) begin
         drive(l[i], c[i]);
         @(posedge clk); #1;
         checks++;
         if (display !== e[i]) begin
            errors++;
            $display("FAIL invalid[%0d]: got %h want %h", i, display, e[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  len;
      logic [4:0]  code;
      logic [6:0]  exp;
      logic [4:0]  junk;
      logic [14:0] ent;
      for (int i = 0; i < 36; i++) begin
         ent  = TBL[i];
         len  = ent[14:12];
         code = ent[11:7];
         exp  = ent[6:0];
         junk = (i % 2 == 1) ? ~(5'h1F >> (5 - len)) : 5'd0;
         drive(len, code | junk);
         @(posedge clk); #1;
         checks++;
         if (display !== exp) begin
            errors++;
            $display("FAIL b2b[%0d] len=%0d code=%b: got %h want %h",
                     i, len, code, display, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(3'd1, 5'b00001);
      @(posedge clk); #1;
      checks++;
      if (display !== 7'h07) begin
         errors++;
         $display("FAIL pre_reset: got %h want 07", display);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (display !== 7'h7F) begin
         errors++;
         $display("FAIL mid_reset: got %h want 7f", display);
      end
      @(posedge clk); #1;
      checks++;
      if (display !== 7'h7F) begin
         errors++;
         $display("FAIL held_reset: got %h want 7f", display);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (display !== 7'h07) begin
         errors++;
         $display("FAIL post_reset: got %h want 07", display);
      end
   endtask

   initial begin
      test_reset();
      test_letters();
      test_digits();
      test_dontcare();
      test_invalid();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
